regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 141 ++++++++++++++
 tb/tb_regfile_mp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port integer register file with a busy
// scoreboard.
//
// Reads are combinational. Writes and scoreboard updates are captured on the
// rising clock edge. The asynchronous active-low reset clears every data word
// and every busy bit.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low clear
//   rs_addr        NRD read addresses, port i at [i*AW +: AW]
//   rs_data        NRD read data words, port i at [i*XLEN +: XLEN]
//   rs_busy        busy status of each read address
//   wr_en          NWR write enables
//   wr_addr        NWR write addresses, port k at [k*AW +: AW]
//   wr_data        NWR write data words, port k at [k*XLEN +: XLEN]
//   busy_set_en    mark busy_set_addr as having a pending producer
//   busy_set_addr  register to mark
//   busy           full scoreboard vector
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                busy_set_en,
    input  logic [AW-1:0]       busy_set_addr,
    output logic [NREG-1:0]     busy
);

    // One past the last valid address, one bit wider than an address so the
    // range test also works when NREG is a power of two.
    localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // -------------------------------------------------------------------------
    // Per-register next-state. Write ports are scanned in ascending order so
    // the highest-index enabled port targeting a register wins. Out-of-range
    // addresses never match any register and are therefore dropped.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (ZERO_REG != 0 && gi == 0) begin : g_zero
            assign mem_d[gi]  = '0;
            assign busy_d[gi] = 1'b0;
        end else begin : g_norm
            logic            wr_hit;
            logic [XLEN-1:0] wr_val;
            logic            set_hit;

            always_comb begin
                wr_hit = 1'b0;
                wr_val = '0;
                for (int k = 0; k < NWR; k++) begin
                    if (wr_en[k] && (wr_addr[k*AW +: AW] == AW'(gi))) begin
                        wr_hit = 1'b1;
                        wr_val = wr_data[k*XLEN +: XLEN];
                    end
                end
            end

            assign set_hit = busy_set_en && (busy_set_addr == AW'(gi));

            assign mem_d[gi]  = wr_hit ? wr_val : mem_q[gi];
            // A new producer issued in the same cycle as the old one's
            // writeback keeps the register busy.
            assign busy_d[gi] = set_hit | (busy_q[gi] & ~wr_hit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            in_range;
        logic            is_zero;
        logic            byp_hit;
        logic            byp_active;
        logic [XLEN-1:0] byp_val;

        assign ra       = rs_addr[gi*AW +: AW];
        assign in_range = ({1'b0, ra} < NREG_LIM);
        assign is_zero  = (ZERO_REG != 0) && (ra == '0);

        always_comb begin
            byp_hit = 1'b0;
            byp_val = '0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == ra)) begin
                    byp_hit = 1'b1;
                    byp_val = wr_data[k*XLEN +: XLEN];
                end
            end
        end

        // Forwarding is suppressed while reset is held so that outputs read
        // zero during the clear, since those writes will never land.
        assign byp_active = (BYPASS != 0) && rst_n && byp_hit;

        assign rs_data[gi*XLEN +: XLEN] = (!in_range || is_zero) ? '0      :
                                          byp_active             ? byp_val :
                                                                   mem_q[ra];

        assign rs_busy[gi] = (!in_range || is_zero || byp_active) ? 1'b0
                                                                  : busy_q[ra];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- directed self-checking bench for regfile_mp.
// Instance A: default parameters (bypass on).
// Instance B: default parameters with BYPASS=0.
// Instance C: XLEN=32, NREG=24, NRD=3, NWR=1.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance A
    logic [9:0]   a_rs_addr = '0;
    logic [127:0] a_rs_data;
    logic [1:0]   a_rs_busy;
    logic [1:0]   a_wr_en = '0;
    logic [9:0]   a_wr_addr = '0;
    logic [127:0] a_wr_data = '0;
    logic         a_bset_en = 1'b0;
    logic [4:0]   a_bset_addr = '0;
    logic [31:0]  a_busy;

    // Instance B
    logic [9:0]   b_rs_addr = '0;
    logic [127:0] b_rs_data;
    logic [1:0]   b_rs_busy;
    logic [1:0]   b_wr_en = '0;
    logic [9:0]   b_wr_addr = '0;
    logic [127:0] b_wr_data = '0;
    logic         b_bset_en = 1'b0;
    logic [4:0]   b_bset_addr = '0;
    logic [31:0]  b_busy;

    // Instance C
    logic [14:0]  c_rs_addr = '0;
    logic [95:0]  c_rs_data;
    logic [2:0]   c_rs_busy;
    logic [0:0]   c_wr_en = '0;
    logic [4:0]   c_wr_addr = '0;
    logic [31:0]  c_wr_data = '0;
    logic         c_bset_en = 1'b0;
    logic [4:0]   c_bset_addr = '0;
    logic [23:0]  c_busy;

    regfile_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(a_rs_addr), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy_set_en(a_bset_en), .busy_set_addr(a_bset_addr), .busy(a_busy)
    );

    regfile_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy_set_en(b_bset_en), .busy_set_addr(b_bset_addr), .busy(b_busy)
    );

    regfile_mp #(.XLEN(32), .NREG(24), .NRD(3), .NWR(1), .ZERO_REG(1), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(c_rs_addr), .rs_data(c_rs_data), .rs_busy(c_rs_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .busy_set_en(c_bset_en), .busy_set_addr(c_bset_addr), .busy(c_busy)
    );

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic a_clear();
        a_wr_en = '0; a_bset_en = 1'b0;
    endtask
    task automatic a_wr(input int p, input logic [4:0] ad, input logic [63:0] d);
        a_wr_en[p] = 1'b1; a_wr_addr[p*5 +: 5] = ad; a_wr_data[p*64 +: 64] = d;
    endtask
    task automatic a_rd(input int p, input logic [4:0] ad);
        a_rs_addr[p*5 +: 5] = ad;
    endtask
    task automatic b_clear();
        b_wr_en = '0; b_bset_en = 1'b0;
    endtask
    task automatic b_wr(input int p, input logic [4:0] ad, input logic [63:0] d);
        b_wr_en[p] = 1'b1; b_wr_addr[p*5 +: 5] = ad; b_wr_data[p*64 +: 64] = d;
    endtask
    task automatic b_rd(input int p, input logic [4:0] ad);
        b_rs_addr[p*5 +: 5] = ad;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_busy !== 32'h0) begin n_fail++; $display("FAIL reset_a_busy: got %h expected 0", a_busy); end
        n_cmp++; if (a_rs_data !== 128'h0) begin n_fail++; $display("FAIL reset_a_rs_data: got %h expected 0", a_rs_data); end
        n_cmp++; if (c_busy !== 24'h0 || c_rs_data !== 96'h0) begin n_fail++; $display("FAIL reset_c: got busy %h data %h expected 0", c_busy, c_rs_data); end
        @(negedge clk) rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_reset_clear();
        @(negedge clk);
        a_wr(0, 5'd5, 64'hDEAD); a_bset_en = 1'b1; a_bset_addr = 5'd6;
        a_rd(0, 5'd5); a_rd(1, 5'd6);
        @(negedge clk);
        a_clear();
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'hDEAD) begin n_fail++; $display("FAIL rclr_pre_data: got %h expected dead", a_rs_data[63:0]); end
        n_cmp++; if (a_busy[6] !== 1'b1 || a_rs_busy[1] !== 1'b1) begin n_fail++; $display("FAIL rclr_pre_busy: got %b/%b expected 1/1", a_busy[6], a_rs_busy[1]); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'h0) begin n_fail++; $display("FAIL rclr_async_data: got %h expected 0", a_rs_data[63:0]); end
        n_cmp++; if (a_busy !== 32'h0 || a_rs_busy !== 2'b00) begin n_fail++; $display("FAIL rclr_async_busy: got %h/%b expected 0/00", a_busy, a_rs_busy); end
        a_wr(1, 5'd5, 64'h1234);
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'h0) begin n_fail++; $display("FAIL rclr_no_bypass_in_reset: got %h expected 0", a_rs_data[63:0]); end
        @(posedge clk); #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'h0) begin n_fail++; $display("FAIL rclr_no_write_in_reset: got %h expected 0", a_rs_data[63:0]); end
        @(negedge clk);
        a_clear(); rst_n = 1'b1;
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'h0) begin n_fail++; $display("FAIL rclr_after_release: got %h expected 0", a_rs_data[63:0]); end
        $display("test_reset_clear done");
    endtask

    task automatic test_fill();
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            a_clear(); a_wr(0, 5'(i), 64'(i) * 64'h0101);
        end
        @(negedge clk);
        a_clear(); a_rd(0, 5'd1); a_rd(1, 5'd31);
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'h0101) begin n_fail++; $display("FAIL fill_r1: got %h expected 0101", a_rs_data[63:0]); end
        n_cmp++; if (a_rs_data[127:64] !== 64'h1F1F) begin n_fail++; $display("FAIL fill_r31: got %h expected 1f1f", a_rs_data[127:64]); end
        a_rd(0, 5'd16); a_rd(1, 5'd2);
        #1;
        n_cmp++; if (a_rs_data !== {64'h0202, 64'h1010}) begin n_fail++; $display("FAIL fill_r16_r2: got %h expected 0202/1010", a_rs_data); end
        @(negedge clk);
        a_wr(0, 5'd0, 64'hFFFF); a_bset_en = 1'b1; a_bset_addr = 5'd0; a_rd(0, 5'd0);
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'h0 || a_rs_busy[0] !== 1'b0) begin n_fail++; $display("FAIL zero_same_cycle: got %h/%b expected 0/0", a_rs_data[63:0], a_rs_busy[0]); end
        @(negedge clk);
        a_clear();
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'h0 || a_busy[0] !== 1'b0) begin n_fail++; $display("FAIL zero_after: got %h/%b expected 0/0", a_rs_data[63:0], a_busy[0]); end
        $display("test_fill done");
    endtask

    task automatic test_collision();
        @(negedge clk);
        a_clear(); a_wr(0, 5'd7, 64'h11); a_wr(1, 5'd7, 64'h22); a_rd(0, 5'd7);
        b_clear(); b_wr(0, 5'd7, 64'h11); b_wr(1, 5'd7, 64'h22); b_rd(0, 5'd7);
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'h22) begin n_fail++; $display("FAIL coll_bypass_winner: got %h expected 22", a_rs_data[63:0]); end
        @(negedge clk);
        a_clear(); a_wr(0, 5'd8, 64'h33); a_wr(1, 5'd10, 64'h44); a_rd(0, 5'd7); a_rd(1, 5'd8);
        b_clear();
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'h22) begin n_fail++; $display("FAIL coll_a_r7: got %h expected 22", a_rs_data[63:0]); end
        n_cmp++; if (a_rs_data[127:64] !== 64'h33) begin n_fail++; $display("FAIL coll_a_r8_bypass: got %h expected 33", a_rs_data[127:64]); end
        n_cmp++; if (b_rs_data[63:0] !== 64'h22) begin n_fail++; $display("FAIL coll_b_r7: got %h expected 22", b_rs_data[63:0]); end
        @(negedge clk);
        a_clear(); a_rd(0, 5'd8); a_rd(1, 5'd10);
        #1;
        n_cmp++; if (a_rs_data !== {64'h44, 64'h33}) begin n_fail++; $display("FAIL coll_independent: got %h expected 44/33", a_rs_data); end
        $display("test_collision done");
    endtask

    task automatic test_bypass();
        @(negedge clk);
        a_clear(); a_wr(0, 5'd9, 64'hABCD); a_rd(0, 5'd9); a_rd(1, 5'd10);
        b_clear(); b_wr(0, 5'd9, 64'h9999); b_bset_en = 1'b1; b_bset_addr = 5'd9; b_rd(0, 5'd9);
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'hABCD) begin n_fail++; $display("FAIL byp_a_same_cycle: got %h expected abcd", a_rs_data[63:0]); end
        n_cmp++; if (a_rs_data[127:64] !== 64'h44) begin n_fail++; $display("FAIL byp_a_other_port: got %h expected 44", a_rs_data[127:64]); end
        @(negedge clk);
        a_clear();
        b_clear(); b_wr(1, 5'd9, 64'hABCD);
        #1;
        n_cmp++; if (a_rs_data[63:0] !== 64'hABCD) begin n_fail++; $display("FAIL byp_a_stored: got %h expected abcd", a_rs_data[63:0]); end
        n_cmp++; if (b_rs_data[63:0] !== 64'h9999) begin n_fail++; $display("FAIL nobyp_b_old: got %h expected 9999", b_rs_data[63:0]); end
        n_cmp++; if (b_rs_busy[0] !== 1'b1) begin n_fail++; $display("FAIL nobyp_b_busy: got %b expected 1", b_rs_busy[0]); end
        @(negedge clk);
        b_clear();
        #1;
        n_cmp++; if (b_rs_data[63:0] !== 64'hABCD) begin n_fail++; $display("FAIL nobyp_b_next: got %h expected abcd", b_rs_data[63:0]); end
        n_cmp++; if (b_rs_busy[0] !== 1'b0) begin n_fail++; $display("FAIL nobyp_b_busy_clr: got %b expected 0", b_rs_busy[0]); end
        $display("test_bypass done");
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        a_clear(); a_bset_en = 1'b1; a_bset_addr = 5'd12; a_rd(0, 5'd12);
        #1;
        n_cmp++; if (a_rs_busy[0] !== 1'b0 || a_busy[12] !== 1'b0) begin n_fail++; $display("FAIL sb_pre_set: got %b/%b expected 0/0", a_rs_busy[0], a_busy[12]); end
        @(negedge clk);
        a_clear();
        #1;
        n_cmp++; if (a_rs_busy[0] !== 1'b1 || a_busy[12] !== 1'b1) begin n_fail++; $display("FAIL sb_set: got %b/%b expected 1/1", a_rs_busy[0], a_busy[12]); end
        @(negedge clk);
        a_wr(1, 5'd12, 64'h77);
        #1;
        n_cmp++; if (a_rs_busy[0] !== 1'b0 || a_busy[12] !== 1'b1) begin n_fail++; $display("FAIL sb_write_bypass: got %b/%b expected 0/1", a_rs_busy[0], a_busy[12]); end
        @(negedge clk);
        a_clear();
        #1;
        n_cmp++; if (a_busy[12] !== 1'b0 || a_rs_data[63:0] !== 64'h77) begin n_fail++; $display("FAIL sb_cleared: got %b/%h expected 0/77", a_busy[12], a_rs_data[63:0]); end
        @(negedge clk);
        a_bset_en = 1'b1; a_bset_addr = 5'd12; a_wr(0, 5'd12, 64'h88);
        @(negedge clk);
        a_clear();
        #1;
        n_cmp++; if (a_busy !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_set_wins: got %h expected 00001000", a_busy); end
        n_cmp++; if (a_rs_busy[0] !== 1'b1 || a_rs_data[63:0] !== 64'h88) begin n_fail++; $display("FAIL sb_set_wins_read: got %b/%h expected 1/88", a_rs_busy[0], a_rs_data[63:0]); end
        $display("test_scoreboard done");
    endtask

    task automatic test_sweep();
        @(negedge clk);
        c_wr_en = 1'b1; c_wr_addr = 5'd30; c_wr_data = 32'hDEAD0001;
        c_bset_en = 1'b1; c_bset_addr = 5'd30;
        c_rs_addr = {5'd23, 5'd6, 5'd30};
        #1;
        n_cmp++; if (c_rs_data !== 96'h0 || c_rs_busy !== 3'b000) begin n_fail++; $display("FAIL sweep_oob_same: got %h/%b expected 0/000", c_rs_data, c_rs_busy); end
        @(negedge clk);
        c_wr_en = 1'b0; c_bset_en = 1'b0;
        #1;
        n_cmp++; if (c_rs_data !== 96'h0 || c_busy !== 24'h0) begin n_fail++; $display("FAIL sweep_oob_ignored: got %h/%h expected 0/0", c_rs_data, c_busy); end
        @(negedge clk);
        c_wr_en = 1'b1; c_wr_addr = 5'd1;  c_wr_data = 32'h11111111;
        @(negedge clk);
        c_wr_addr = 5'd22; c_wr_data = 32'h22222222;
        @(negedge clk);
        c_wr_addr = 5'd23; c_wr_data = 32'h23232323; c_bset_en = 1'b1; c_bset_addr = 5'd5;
        @(negedge clk);
        c_wr_en = 1'b0; c_bset_en = 1'b0; c_rs_addr = {5'd23, 5'd22, 5'd1};
        #1;
        n_cmp++; if (c_rs_data !== {32'h23232323, 32'h22222222, 32'h11111111}) begin n_fail++; $display("FAIL sweep_three_ports: got %h expected 23232323_22222222_11111111", c_rs_data); end
        n_cmp++; if (c_busy !== 24'h000020) begin n_fail++; $display("FAIL sweep_busy_vec: got %h expected 000020", c_busy); end
        c_rs_addr = {5'd0, 5'd30, 5'd5};
        #1;
        n_cmp++; if (c_rs_busy !== 3'b001 || c_rs_data !== 96'h0) begin n_fail++; $display("FAIL sweep_busy_read: got %b/%h expected 001/0", c_rs_busy, c_rs_data); end
        $display("test_sweep done");
    endtask

    initial begin
        test_reset();
        test_reset_clear();
        test_fill();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
